// File: rtl/draw_menu_items_if.sv
// vga_if: one VGA pipeline stage boundary.
//   hcount/vcount : 11-bit pixel position
//   hsync/vsync   : sync pulses
//   hblnk/vblnk   : blanking flags
//   rgb           : 12-bit colour (4 bits per channel)
// Modport "in" is the consumer side, modport "out" the producer side.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_menu_items.sv
// draw_menu_items: menu background drawer with N_ITEMS stacked item boxes and
// a frame-synchronous highlight cursor.
//   clk, rst_n          : pixel clock, asynchronous active-low reset
//   in  (vga_if.in)     : timing from upstream (upstream rgb is replaced)
//   out (vga_if.out)    : timing delayed by one cycle plus the drawn rgb
//   btn_up/down/sel     : synchronised level buttons
//   sel_idx             : committed highlighted item index
//   sel_valid           : one-cycle pulse when a selection is confirmed
// Optional build macro MENU_BLINK_EN: the highlight blinks with a half-period
// of BLINK_FRAMES frames; a committed move restarts the blink in the lit phase.
module draw_menu_items #(
  parameter int          N_ITEMS      = 4,
  parameter int          ITEM_X0      = 384,
  parameter int          ITEM_Y0      = 160,
  parameter int          ITEM_W       = 256,
  parameter int          ITEM_H       = 64,
  parameter int          ITEM_GAP     = 32,
  parameter logic [11:0] BG_COLOR     = 12'h2_2_4,
  parameter logic [11:0] ITEM_COLOR   = 12'h4_4_8,
  parameter logic [11:0] SEL_COLOR    = 12'hf_c_0,
  parameter int          BLINK_FRAMES = 16,
  parameter int          HOR_PIXELS   = 1024,
  parameter int          VER_PIXELS   = 768,
  localparam int         IDX_W        = $clog2(N_ITEMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_if.in                in,
  vga_if.out               out,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_sel,
  output logic [IDX_W-1:0] sel_idx,
  output logic             sel_valid
);

  typedef enum logic [1:0] {
    MOVE_NONE = 2'b00,
    MOVE_UP   = 2'b01,
    MOVE_DOWN = 2'b10
  } move_e;

  localparam logic [11:0] X_LO    = 12'(ITEM_X0);
  localparam logic [11:0] X_HI    = 12'(ITEM_X0 + ITEM_W);
  localparam logic [11:0] H_LAST  = 12'(HOR_PIXELS - 1);
  localparam logic [11:0] V_LAST  = 12'(VER_PIXELS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ITEMS - 1);

  // Top row of box i, wrapped to 12 bits like the pixel counters.
  function automatic logic [11:0] box_top(input int i);
    return 12'(ITEM_Y0 + i * (ITEM_H + ITEM_GAP));
  endfunction

  logic [10:0]      hcount_q, vcount_q;
  logic             hsync_q, vsync_q, hblnk_q, vblnk_q;
  logic [11:0]      rgb_q, rgb_nxt;
  logic             vblnk_prev_q;
  logic             btn_up_q, btn_down_q, btn_sel_q;
  logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
  logic             sel_valid_q;
  move_e            pend_q, pend_d;
  logic             rise_up_s, rise_down_s, rise_sel_s, frame_start_s;
  logic [11:0]      h12_s, v12_s, hl_color_s;
  logic             in_box_s, hit_sel_s;
  logic             unused_s;

  assign h12_s         = {1'b0, in.hcount};
  assign v12_s         = {1'b0, in.vcount};
  assign rise_up_s     = btn_up   & ~btn_up_q;
  assign rise_down_s   = btn_down & ~btn_down_q;
  assign rise_sel_s    = btn_sel  & ~btn_sel_q;
  assign frame_start_s = in.vblnk & ~vblnk_prev_q;

`ifdef MENU_BLINK_EN
  localparam int CNT_W = $clog2(BLINK_FRAMES) + 1;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;

  // Blink counter: advances per frame, restarts when a move commits.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (frame_start_s) begin
      if (pend_q != MOVE_NONE) begin
        blink_cnt_d = '0;
        phase_d     = 1'b0;
      end else if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
        // Incrementing would reach BLINK_FRAMES: toggle and wrap.
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
  end

  // Blink state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign hl_color_s = phase_q ? ITEM_COLOR : SEL_COLOR;
  assign unused_s   = ^in.rgb;
`else
  assign hl_color_s = SEL_COLOR;
  assign unused_s   = (^in.rgb) ^ (BLINK_FRAMES > 0);
`endif

  // Box hit test; boxes never overlap, so at most one can match.
  always_comb begin
    in_box_s  = 1'b0;
    hit_sel_s = 1'b0;
    for (int i = 0; i < N_ITEMS; i++) begin
      if ((h12_s >= X_LO) && (h12_s < X_HI) &&
          (v12_s >= box_top(i)) && (v12_s < box_top(i) + 12'(ITEM_H))) begin
        in_box_s  = 1'b1;
        hit_sel_s = hit_sel_s | (IDX_W'(i) == sel_idx_q);
      end else begin
        in_box_s  = in_box_s;
      end
    end
  end

  // Pixel colour priority: blanking, edge markers, boxes, background.
  always_comb begin
    rgb_nxt = BG_COLOR;
    if (in.vblnk || in.hblnk) begin
      rgb_nxt = 12'h0_0_0;
    end else if (v12_s == 12'd0) begin
      rgb_nxt = 12'hf_f_0;
    end else if (v12_s == V_LAST) begin
      rgb_nxt = 12'hf_0_0;
    end else if (h12_s == 12'd0) begin
      rgb_nxt = 12'h0_f_0;
    end else if (h12_s == H_LAST) begin
      rgb_nxt = 12'h0_0_f;
    end else if (in_box_s) begin
      rgb_nxt = hit_sel_s ? hl_color_s : ITEM_COLOR;
    end else begin
      rgb_nxt = BG_COLOR;
    end
  end

  // Cursor: apply the pending move at frame start, then latch any new edge.
  always_comb begin
    sel_idx_d = sel_idx_q;
    pend_d    = pend_q;
    if (frame_start_s) begin
      case (pend_q)
        MOVE_UP:   sel_idx_d = (sel_idx_q == '0) ? IDX_LAST : sel_idx_q - IDX_W'(1);
        MOVE_DOWN: sel_idx_d = (sel_idx_q == IDX_LAST) ? '0 : sel_idx_q + IDX_W'(1);
        default:   sel_idx_d = sel_idx_q;
      endcase
      pend_d = MOVE_NONE;
    end else begin
      sel_idx_d = sel_idx_q;
    end
    // Simultaneous up and down edges cancel and leave the pending move alone.
    if (rise_up_s && !rise_down_s) begin
      pend_d = MOVE_UP;
    end else if (rise_down_s && !rise_up_s) begin
      pend_d = MOVE_DOWN;
    end else begin
      pend_d = pend_d;
    end
  end

  // Video pipeline stage and control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q     <= 11'd0;
      vcount_q     <= 11'd0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      hblnk_q      <= 1'b0;
      vblnk_q      <= 1'b0;
      rgb_q        <= 12'h0_0_0;
      vblnk_prev_q <= 1'b0;
      btn_up_q     <= 1'b0;
      btn_down_q   <= 1'b0;
      btn_sel_q    <= 1'b0;
      sel_idx_q    <= '0;
      sel_valid_q  <= 1'b0;
      pend_q       <= MOVE_NONE;
    end else begin
      hcount_q     <= in.hcount;
      vcount_q     <= in.vcount;
      hsync_q      <= in.hsync;
      vsync_q      <= in.vsync;
      hblnk_q      <= in.hblnk;
      vblnk_q      <= in.vblnk;
      rgb_q        <= rgb_nxt;
      vblnk_prev_q <= in.vblnk;
      btn_up_q     <= btn_up;
      btn_down_q   <= btn_down;
      btn_sel_q    <= btn_sel;
      sel_idx_q    <= sel_idx_d;
      sel_valid_q  <= rise_sel_s;
      pend_q       <= pend_d;
    end
  end

  assign out.hcount = hcount_q;
  assign out.vcount = vcount_q;
  assign out.hsync  = hsync_q;
  assign out.vsync  = vsync_q;
  assign out.hblnk  = hblnk_q;
  assign out.vblnk  = vblnk_q;
  assign out.rgb    = rgb_q;
  assign sel_idx    = sel_idx_q;
  assign sel_valid  = sel_valid_q;

endmodule

// File: tb/tb_draw_menu_items.sv
module tb_draw_menu_items;
  localparam int N  = 4;
  localparam int BF = 2;

  typedef struct {
    logic [11:0] rgb;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down, btn_sel;
  logic [1:0] sel_idx;
  logic       sel_valid;

  vga_if vin ();
  vga_if vout ();

  draw_menu_items #(.N_ITEMS(N), .BLINK_FRAMES(BF)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (vin),
    .out       (vout),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_sel   (btn_sel),
    .sel_idx   (sel_idx),
    .sel_valid (sel_valid)
  );

  always #5 clk = ~clk;

  exp_t  expq[$];
  string tagq[$];
  int    errors = 0;
  int    checks = 0;
  int    exp_sel = 0;
  int    bcnt = 0;
  logic  bph = 1'b0;

  // Expected colour of the highlighted box under the bench's blink model.
  function automatic logic [11:0] hl();
`ifdef MENU_BLINK_EN
    return bph ? 12'h448 : 12'hfc0;
`else
    return 12'hfc0;
`endif
  endfunction

  // Drive one pixel, push its expectation, then compare one cycle later.
  task automatic step(input int h, input int v, input logic hb, input logic vb,
                      input logic [11:0] exp_rgb, input string tag);
    exp_t  e;
    exp_t  g;
    string t;
    e.h = 11'(h); e.v = 11'(v); e.hb = hb; e.vb = vb;
    e.hs = 1'($urandom); e.vs = 1'($urandom); e.rgb = exp_rgb;
    vin.hcount = e.h; vin.vcount = e.v; vin.hsync = e.hs; vin.vsync = e.vs;
    vin.hblnk = hb; vin.vblnk = vb; vin.rgb = 12'($urandom);
    expq.push_back(e);
    tagq.push_back(tag);
    @(posedge clk);
    #1;
    g = expq.pop_front();
    t = tagq.pop_front();
    checks++;
    assert (vout.rgb === g.rgb) else begin
      errors++;
      $error("FAIL %s rgb: observed=%h expected=%h", t, vout.rgb, g.rgb);
    end
    checks++;
    assert ({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}
            === {g.h, g.v, g.hs, g.vs, g.hb, g.vb}) else begin
      errors++;
      $error("FAIL %s timing: observed=%0d,%0d,%b%b%b%b expected=%0d,%0d,%b%b%b%b", t,
             vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk,
             g.h, g.v, g.hs, g.vs, g.hb, g.vb);
    end
  endtask

  task automatic check_sel(input string tag);
    checks++;
    assert (sel_idx === 2'(exp_sel)) else begin
      errors++;
      $error("FAIL %s sel_idx: observed=%0d expected=%0d", tag, sel_idx, exp_sel);
    end
  endtask

  // One vblnk rising edge; move is the commit the bench expects (-1/0/+1).
  task automatic frame_edge(input int move, input logic press_dn);
    btn_down = press_dn;
    step(100, 780, 1'b0, 1'b1, 12'h000, "vblank");
    btn_down = 1'b0;
    exp_sel = (exp_sel + move + N) % N;
    if (move != 0) begin
      bcnt = 0;
      bph  = 1'b0;
    end else begin
      bcnt++;
      if (bcnt == BF) begin
        bph  = ~bph;
        bcnt = 0;
      end
    end
    check_sel("commit");
    step(1100, 780, 1'b1, 1'b0, 12'h000, "vblank_end");
  endtask

  task automatic press(input logic up, input logic dn);
    btn_up = up; btn_down = dn;
    step(100, 100, 1'b0, 1'b0, 12'h224, "press");
    btn_up = 1'b0; btn_down = 1'b0;
    step(100, 100, 1'b0, 1'b0, 12'h224, "release");
  endtask

  initial begin
    int   pulses;
    logic [1:0] pulse_idx;
    rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
    vin.hcount = 11'd0; vin.vcount = 11'd0; vin.hsync = 1'b1; vin.vsync = 1'b1;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'hfff;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert ({vout.rgb, vout.hcount, vout.vcount, vout.hsync, vout.vsync, sel_idx, sel_valid}
            === {12'h000, 11'd0, 11'd0, 1'b0, 1'b0, 2'd0, 1'b0}) else begin
      errors++;
      $error("FAIL reset: observed rgb=%h sel=%0d valid=%b expected all zero",
             vout.rgb, sel_idx, sel_valid);
    end
    rst_n = 1'b1;

    // Static picture with item 0 highlighted.
    step(10, 0, 1'b0, 1'b0, 12'hff0, "top");
    step(10, 767, 1'b0, 1'b0, 12'hf00, "bottom");
    step(0, 10, 1'b0, 1'b0, 12'h0f0, "left");
    step(1023, 10, 1'b0, 1'b0, 12'h00f, "right");
    step(0, 0, 1'b0, 1'b0, 12'hff0, "corner_top_left");
    step(1023, 767, 1'b0, 1'b0, 12'hf00, "corner_bot_right");
    step(0, 0, 1'b1, 1'b0, 12'h000, "hblank_over_edge");
    step(400, 170, 1'b0, 1'b0, hl(), "box0");
    step(400, 270, 1'b0, 1'b0, 12'h448, "box1");
    step(100, 100, 1'b0, 1'b0, 12'h224, "bg");
    step(383, 170, 1'b0, 1'b0, 12'h224, "box0_left_out");
    step(384, 160, 1'b0, 1'b0, hl(), "box0_top_left");
    step(639, 223, 1'b0, 1'b0, hl(), "box0_bot_right");
    step(640, 170, 1'b0, 1'b0, 12'h224, "box0_right_out");
    step(400, 224, 1'b0, 1'b0, 12'h224, "gap");
    step(400, 256, 1'b0, 1'b0, 12'h448, "box1_top");
    step(639, 511, 1'b0, 1'b0, 12'h448, "box3_last");
    step(400, 512, 1'b0, 1'b0, 12'h224, "below_boxes");
    frame_edge(0, 1'b0);

    // Down pressed mid-frame: picture holds until the frame boundary.
    btn_down = 1'b1;
    step(400, 300, 1'b0, 1'b0, 12'h448, "down_mid_frame");
    btn_down = 1'b0;
    step(400, 170, 1'b0, 1'b0, hl(), "box0_still_sel");
    check_sel("no_early_commit");
    frame_edge(1, 1'b0);
    step(400, 270, 1'b0, 1'b0, hl(), "box1_sel");
    step(400, 170, 1'b0, 1'b0, 12'h448, "box0_unsel");

    // Up twice: 1 -> 0 -> 3 (wrap).
    press(1'b1, 1'b0);
    frame_edge(-1, 1'b0);
    press(1'b1, 1'b0);
    frame_edge(-1, 1'b0);
    step(400, 460, 1'b0, 1'b0, hl(), "box3_sel");

    // Four downs, one per frame: 3 -> 0 -> 1 -> 2 -> 3.
    for (int k = 0; k < 4; k++) begin
      press(1'b0, 1'b1);
      frame_edge(1, 1'b0);
    end

    // Simultaneous edges cancel.
    press(1'b1, 1'b1);
    frame_edge(0, 1'b0);

    // Later edge wins: down then up -> up (3 -> 2).
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    frame_edge(-1, 1'b0);

    // Edge in the commit cycle becomes the next pending move.
    frame_edge(0, 1'b1);
    frame_edge(1, 1'b0);
    press(1'b1, 1'b0);
    frame_edge(-1, 1'b0);

    // Held select with a concurrent pending down: one pulse reporting 2.
    pulses = 0;
    pulse_idx = 2'd0;
    btn_sel = 1'b1;
    btn_down = 1'b1;
    for (int k = 0; k < 100; k++) begin
      step(100, 100, 1'b0, 1'b0, 12'h224, "sel_hold");
      btn_down = 1'b0;
      if (sel_valid === 1'b1) begin
        pulses++;
        pulse_idx = sel_idx;
      end
    end
    btn_sel = 1'b0;
    checks++;
    assert (pulses == 1) else begin
      errors++;
      $error("FAIL sel_pulses: observed=%0d expected=1", pulses);
    end
    checks++;
    assert (pulse_idx === 2'd2) else begin
      errors++;
      $error("FAIL sel_reported_idx: observed=%0d expected=2", pulse_idx);
    end
    frame_edge(1, 1'b0);

    // Asynchronous reset mid-line.
    step(400, 170, 1'b0, 1'b0, 12'h448, "pre_reset");
    vin.hcount = 11'd500; vin.vcount = 11'd300;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({vout.rgb, vout.hcount, sel_idx, sel_valid} === {12'h000, 11'd0, 2'd0, 1'b0}) else begin
      errors++;
      $error("FAIL async_reset: observed rgb=%h h=%0d sel=%0d expected rgb=000 h=0 sel=0",
             vout.rgb, vout.hcount, sel_idx);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_sel = 0; bcnt = 0; bph = 1'b0;
    step(400, 170, 1'b0, 1'b0, hl(), "box0_after_reset");
    step(400, 460, 1'b0, 1'b0, 12'h448, "box3_after_reset");

    // Highlight across several frames, then restart after a move.
    for (int k = 0; k < 5; k++) begin
      frame_edge(0, 1'b0);
      step(400, 170, 1'b0, 1'b0, hl(), "blink_frame");
    end
    press(1'b0, 1'b1);
    frame_edge(1, 1'b0);
    step(400, 270, 1'b0, 1'b0, hl(), "blink_restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
